// File: rtl/spart_echo_driver.sv
// SPART echo driver: programs the baud divisor selected by br_cfg, then
// echoes received bytes back to the SPART through a DEPTH-entry FIFO.
// The divisor is re-programmed after a br_cfg change once queued bytes drain.
module spart_echo_driver #(
  parameter int unsigned CLK_HZ    = 25000000,
  parameter int unsigned BAUD_BASE = 4800,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             br_cfg,
  output logic                   iocs,
  output logic                   iorw,
  input  logic                   rda,
  input  logic                   tbr,
  output logic [1:0]             ioaddr,
  inout  wire  [7:0]             databus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic                   cfg_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RX,
    TX,
    SETTLE
  } state_t;

  function automatic logic [15:0] div_of(input logic [1:0] n);
    return 16'(CLK_HZ / (BAUD_BASE << n));
  endfunction

  state_t        state_q, state_d;
  logic          iocs_q, iorw_q;
  logic [1:0]    ioaddr_q;
  logic [7:0]    data_q;
  logic [1:0]    br_cfg_q;
  logic          pending_q;
  logic          last_rx_q;
  logic          cfg_done_q;
  logic          overflow_q;
  logic [7:0]    drop_q;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [7:0]    mem_q [DEPTH];

  logic          fifo_empty, fifo_full, mismatch, pend;
  logic          rx_ok, tx_ok, reconfig, load_cfg;
  logic [1:0]    cfg_sel;
  logic [15:0]   div_w;

  // Arbitration, reconfiguration and next-state decode
  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);
    mismatch   = (br_cfg != br_cfg_q);
    pend       = pending_q | mismatch;
    rx_ok      = rda & ~pend;
    tx_ok      = tbr & ~fifo_empty;
    reconfig   = pend & fifo_empty;
    load_cfg   = 1'b0;
    state_d    = state_q;
    case (state_q)
      // Out of reset the CFG_LO cycle has not yet been put on the bus, so
      // the first edge presents it instead of advancing.
      CFG_LO: state_d = iocs_q ? CFG_HI : CFG_LO;
      CFG_HI: state_d = IDLE;
      IDLE: begin
        if (reconfig) begin
          state_d  = CFG_LO;
          load_cfg = 1'b1;
        end else if (rx_ok && tx_ok) begin
          state_d = last_rx_q ? TX : RX;
        end else if (rx_ok) begin
          state_d = RX;
        end else if (tx_ok) begin
          state_d = TX;
        end
      end
      RX:     state_d = SETTLE;
      TX:     state_d = SETTLE;
      SETTLE: begin
        if (reconfig) begin
          state_d  = CFG_LO;
          load_cfg = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = CFG_LO;
    endcase
    cfg_sel = load_cfg ? br_cfg : br_cfg_q;
    div_w   = div_of(cfg_sel);
  end

  // FSM, registered bus outputs, configuration tracking and FIFO bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CFG_LO;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= 2'b00;
      data_q     <= '0;
      br_cfg_q   <= br_cfg;
      pending_q  <= 1'b0;
      last_rx_q  <= 1'b0;
      cfg_done_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q <= state_d;

      // Bus outputs for the cycle being entered
      case (state_d)
        CFG_LO: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= 2'b10;
          data_q   <= div_w[7:0];
        end
        CFG_HI: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= 2'b11;
          data_q   <= div_w[15:8];
        end
        RX: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b1;
          ioaddr_q <= 2'b00;
        end
        TX: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= 2'b00;
          data_q   <= mem_q[rd_q];
        end
        default: begin
          iocs_q   <= 1'b0;
          iorw_q   <= 1'b1;
          ioaddr_q <= 2'b00;
        end
      endcase

      if (load_cfg) begin
        br_cfg_q  <= br_cfg;
        pending_q <= 1'b0;
      end else if (mismatch) begin
        pending_q <= 1'b1;
      end

      if (mismatch || load_cfg) begin
        cfg_done_q <= 1'b0;
      end else if (state_q == CFG_HI && !pending_q) begin
        cfg_done_q <= 1'b1;
      end

      if (state_q == RX) begin
        last_rx_q <= 1'b1;
        if (fifo_full) begin
          overflow_q <= 1'b1;
          if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end else begin
          wr_q  <= wr_q + 1'b1;
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (state_q == TX) begin
        last_rx_q <= 1'b0;
        rd_q      <= rd_q + 1'b1;
        cnt_q     <= cnt_q - 1'b1;
      end
    end
  end

  // FIFO storage, written at the closing edge of a non-dropped read
  always_ff @(posedge clk) begin
    if (state_q == RX && !fifo_full) mem_q[wr_q] <= databus;
  end

  assign databus    = (iocs_q && !iorw_q) ? data_q : 'z;
  assign iocs       = iocs_q;
  assign iorw       = iorw_q;
  assign ioaddr     = ioaddr_q;
  assign fifo_count = cnt_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_q;
  assign cfg_done   = cfg_done_q;

endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench for spart_echo_driver: a small SPART model supplies received bytes
// and logs every bus cycle; tests compare against hand-computed values.
module tb_spart_echo_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b00;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       cfg_done;
  logic [7:0] rx_byte = 8'h00;

  int checks = 0;
  int errors = 0;
  int bad_addr = 0;

  logic [7:0] rxq[$];
  logic [2:0] act_log[$];
  logic [9:0] wr_log[$];
  bit         rd_pend = 1'b0;

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;

  cfg_vec_t   vecs [4];
  logic [9:0] recfg_wr [6];
  logic [2:0] recfg_act [7];

  assign databus = (iocs && iorw) ? rx_byte : 8'hzz;

  spart_echo_driver #(
    .CLK_HZ   (25000000),
    .BAUD_BASE(4800),
    .DEPTH    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .iocs      (iocs),
    .iorw      (iorw),
    .rda       (rda),
    .tbr       (tbr),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .cfg_done  (cfg_done)
  );

  always #5 clk = ~clk;

  // SPART model and bus monitor, evaluated away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      rd_pend = 1'b0;
    end else begin
      if (rd_pend && rxq.size() != 0) void'(rxq.pop_front());
      rd_pend = iocs && iorw;
    end
    rda     = (rxq.size() != 0);
    rx_byte = (rxq.size() != 0) ? rxq[0] : 8'h00;
    if (iocs) begin
      act_log.push_back({iorw, ioaddr});
      if (ioaddr == 2'b01) bad_addr++;
      if (!iorw) wr_log.push_back({ioaddr, databus});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_cfg_seq(input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    chk("cfg_lo_iocs", 32'(iocs), 1);
    chk("cfg_lo_iorw", 32'(iorw), 0);
    chk("cfg_lo_addr", 32'(ioaddr), 2);
    chk("cfg_lo_data", 32'(databus), 32'(lo));
    @(negedge clk);
    chk("cfg_hi_iocs", 32'(iocs), 1);
    chk("cfg_hi_addr", 32'(ioaddr), 3);
    chk("cfg_hi_data", 32'(databus), 32'(hi));
    @(negedge clk);
    chk("cfg_done_set", 32'(cfg_done), 1);
    chk("cfg_idle_iocs", 32'(iocs), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    vecs[0] = '{cfg: 2'b11, lo: 8'h8B, hi: 8'h02};
    vecs[1] = '{cfg: 2'b01, lo: 8'h2C, hi: 8'h0A};
    vecs[2] = '{cfg: 2'b10, lo: 8'h16, hi: 8'h05};
    vecs[3] = '{cfg: 2'b00, lo: 8'h58, hi: 8'h14};
    recfg_wr  = '{10'h041, 10'h042, 10'h043, 10'h216, 10'h305, 10'h044};
    recfg_act = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b011, 3'b100, 3'b000};

    // Reset state and first configuration
    cyc(2);
    chk("rst_iocs", 32'(iocs), 0);
    chk("rst_iorw", 32'(iorw), 1);
    chk("rst_addr", 32'(ioaddr), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);
    rst = 1'b1;
    check_cfg_seq(8'h58, 8'h14);

    // Divisor table through the reconfiguration path
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      wr_log.delete();
      br_cfg = vecs[i].cfg;
      @(negedge clk);
      chk("cfg_done_drop", 32'(cfg_done), 0);
      cyc(6);
      chk("cfg_nwr", 32'(wr_log.size()), 2);
      if (wr_log.size() == 2) begin
        chk("cfg_tab_lo", 32'(wr_log[0]), 32'({2'b10, vecs[i].lo}));
        chk("cfg_tab_hi", 32'(wr_log[1]), 32'({2'b11, vecs[i].hi}));
      end
      chk("cfg_tab_done", 32'(cfg_done), 1);
    end

    // Single echo, cycle by cycle
    @(negedge clk); #2;
    tbr = 1'b1;
    rxq.push_back(8'hA5);
    @(negedge clk);
    @(negedge clk);
    chk("echo_rx_iocs", 32'(iocs), 1);
    chk("echo_rx_iorw", 32'(iorw), 1);
    chk("echo_rx_addr", 32'(ioaddr), 0);
    @(negedge clk);
    chk("echo_settle_count", 32'(fifo_count), 1);
    chk("echo_settle_iocs", 32'(iocs), 0);
    @(negedge clk);
    chk("echo_idle_iocs", 32'(iocs), 0);
    @(negedge clk);
    chk("echo_tx_iocs", 32'(iocs), 1);
    chk("echo_tx_iorw", 32'(iorw), 0);
    chk("echo_tx_addr", 32'(ioaddr), 0);
    chk("echo_tx_data", 32'(databus), 'hA5);
    @(negedge clk);
    chk("echo_done_count", 32'(fifo_count), 0);

    // Burst with tbr low: overflow, then ordered drain across the wrap
    @(negedge clk); #2;
    tbr = 1'b0;
    wr_log.delete();
    for (int b = 1; b <= 10; b++) rxq.push_back(8'(b));
    cyc(60);
    chk("burst_count", 32'(fifo_count), 8);
    chk("burst_ovf", 32'(overflow), 1);
    chk("burst_drop", 32'(drop_cnt), 2);
    chk("burst_no_tx", 32'(wr_log.size()), 0);
    chk("burst_rxq_empty", 32'(rxq.size()), 0);
    @(negedge clk); #2;
    tbr = 1'b1;
    cyc(40);
    chk("drain_nwr", 32'(wr_log.size()), 8);
    for (int k = 0; k < 8 && k < wr_log.size(); k++)
      chk("drain_data", 32'(wr_log[k]), 32'(k + 1));
    chk("drain_count", 32'(fifo_count), 0);
    chk("drain_drop_kept", 32'(drop_cnt), 2);

    // rda and tbr both high: strict RX/TX alternation
    @(negedge clk); #2;
    act_log.delete();
    wr_log.delete();
    for (int b = 0; b < 6; b++) rxq.push_back(8'h30 + 8'(b));
    cyc(60);
    chk("alt_nact", 32'(act_log.size()), 12);
    for (int k = 0; k < 12 && k < act_log.size(); k++)
      chk("alt_kind", 32'(act_log[k]), (k % 2 == 0) ? 'b100 : 'b000);
    chk("alt_nwr", 32'(wr_log.size()), 6);
    for (int k = 0; k < 6 && k < wr_log.size(); k++)
      chk("alt_data", 32'(wr_log[k]), 'h30 + k);

    // br_cfg change with 3 bytes queued: drain, reprogram, then RX resumes
    @(negedge clk); #2;
    tbr = 1'b0;
    for (int b = 0; b < 3; b++) rxq.push_back(8'h41 + 8'(b));
    cyc(20);
    chk("recfg_queued", 32'(fifo_count), 3);
    @(negedge clk); #2;
    br_cfg = 2'b10;
    rxq.push_back(8'h44);
    act_log.delete();
    wr_log.delete();
    @(negedge clk);
    chk("recfg_done_drop", 32'(cfg_done), 0);
    cyc(3);
    chk("recfg_rx_held", 32'(fifo_count), 3);
    chk("recfg_no_act", 32'(act_log.size()), 0);
    @(negedge clk); #2;
    tbr = 1'b1;
    cyc(30);
    chk("recfg_nact", 32'(act_log.size()), 7);
    for (int k = 0; k < 7 && k < act_log.size(); k++)
      chk("recfg_act", 32'(act_log[k]), 32'(recfg_act[k]));
    chk("recfg_nwr", 32'(wr_log.size()), 6);
    for (int k = 0; k < 6 && k < wr_log.size(); k++)
      chk("recfg_wr", 32'(wr_log[k]), 32'(recfg_wr[k]));
    chk("recfg_done_set", 32'(cfg_done), 1);
    chk("recfg_count", 32'(fifo_count), 0);

    // Reset asserted during a TX cycle
    @(negedge clk); #2;
    tbr = 1'b0;
    rxq.push_back(8'h51);
    rxq.push_back(8'h52);
    cyc(15);
    chk("rtx_queued", 32'(fifo_count), 2);
    #2;
    tbr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (iocs && !iorw && ioaddr == 2'b00) found = 1'b1;
    end
    chk("rtx_tx_seen", 32'(found), 1);
    #1;
    rst = 1'b0;
    br_cfg = 2'b11;
    #1;
    chk("rtx_iocs", 32'(iocs), 0);
    chk("rtx_count", 32'(fifo_count), 0);
    chk("rtx_ovf", 32'(overflow), 0);
    chk("rtx_drop", 32'(drop_cnt), 0);
    chk("rtx_cfg_done", 32'(cfg_done), 0);
    @(negedge clk);
    @(negedge clk);
    chk("rtx_hold_iocs", 32'(iocs), 0);
    rst = 1'b1;
    check_cfg_seq(8'h8B, 8'h02);

    chk("no_status_addr", 32'(bad_addr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_echo_driver.md
Name: spart_echo_driver

Overview:
- Parametrised successor to the SPART bring-up driver.
- Programs the SPART baud divisor from br_cfg, then echoes received bytes back out through a DEPTH-entry elastic FIFO. The FIFO absorbs bursts while tbr is low.
- Re-programs the divisor whenever br_cfg changes, once pending echo data has drained.
- Sits between board switches and the SPART processor-side bus. Adds chip-select discipline, fairness and overflow accounting.

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz.
- BAUD_BASE, 4800, baud rate for br_cfg=00. Baud for br_cfg=n is BAUD_BASE<<n.
- DEPTH, 8, echo FIFO entries. Must be a power of two, ≥2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- br_cfg  input  2  baud select; treated as quasi-static, registered once before use
- iocs  output  1  SPART chip select, active high
- iorw  output  1  1=read, 0=write
- rda  input  1  SPART receive data available
- tbr  input  1  SPART transmit buffer ready
- ioaddr  output  2  00 data, 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  driven only while iocs=1 and iorw=0, else high-Z
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky; set when a byte is dropped
- drop_cnt  output  8  dropped bytes, saturates at 255
- cfg_done  output  1  high once the divisor is programmed for the current br_cfg

Behaviour:
- Clock and reset: all state uses clk and asynchronous active-low rst.
- Reset values:
  - state=CFG_LO, iocs=0, iorw=1, ioaddr=00, databus Z
  - fifo_count=0, overflow=0, drop_cnt=0, cfg_done=0
  - br_cfg_q=br_cfg, last_served=TX
- Divisor: DIV[n] = CLK_HZ/(BAUD_BASE<<n), integer truncation, computed at elaboration, 16 bits. Defaults: 0x1458, 0x0A2C, 0x0516, 0x028B.
- States:
  - CFG_LO (1 cycle): iocs=1, iorw=0, ioaddr=10, databus=DIV[br_cfg_q][7:0]. Next: CFG_HI.
  - CFG_HI (1 cycle): iocs=1, iorw=0, ioaddr=11, databus=DIV[br_cfg_q][15:8]. Set cfg_done at cycle end. Next: IDLE.
  - IDLE: iocs=0. Arbitration:
    - rda only → RX.
    - tbr and FIFO non-empty only → TX.
    - Both eligible → serve the opposite of last_served.
    - Neither → stay.
  - RX (1 cycle): iocs=1, iorw=1, ioaddr=00. Sample databus at the closing clk edge.
    - FIFO not full: push the byte.
    - FIFO full: discard it, set overflow, drop_cnt++ (saturating).
    - The read is always performed so the SPART clears rda.
    - last_served=RX. Next: SETTLE.
  - TX (1 cycle): iocs=1, iorw=0, ioaddr=00, databus=FIFO head. Pop at the closing edge. last_served=TX. Next: SETTLE.
  - SETTLE (1 cycle): iocs=0, lets rda/tbr update. Next: IDLE, or CFG_LO if a reconfig is pending and the FIFO is empty.
- Reconfiguration:
  - When br_cfg != br_cfg_q in any state: set pending and clear cfg_done.
  - In IDLE with pending set and the FIFO empty: load br_cfg_q=br_cfg, clear pending, go to CFG_LO. This takes priority over RX/TX.
  - While pending with a non-empty FIFO: RX is suppressed (new bytes wait in the SPART) and TX continues until the FIFO drains.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - fifo_count distinguishes full (DEPTH) from empty (0).
  - Push and pop never occur in the same cycle, because RX and TX are exclusive states.
- Bus rule: ioaddr=01 is never issued; status comes from the rda/tbr pins.
- Reset mid-transaction: iocs drops and databus releases asynchronously. Pointers clear. Configuration restarts at CFG_LO.

Test Plan:
- Reset release, br_cfg=00 → cycle 1: iocs=1, iorw=0, ioaddr=10, bus=0x58; cycle 2: ioaddr=11, bus=0x14; then cfg_done=1, iocs=0. Repeat for br_cfg=11 → 0x8B, 0x02.
- Single echo: pulse rda with bus=0xA5, tbr=1 → RX read, fifo_count=1, SETTLE, TX write of 0xA5 on addr 00, fifo_count=0.
- Burst with tbr=0: feed DEPTH+2 bytes 0x01.. → fifo_count=8, overflow=1, drop_cnt=2. Then raise tbr → bytes 0x01..0x08 transmitted in order, pointers wrap cleanly.
- rda and tbr held high with a non-empty FIFO → strict RX/TX alternation, each separated by one SETTLE cycle.
- Change br_cfg 00→10 with 3 bytes queued → TX drains all 3 with no RX. Then CFG_LO/CFG_HI write 0x16/0x05, cfg_done re-asserts, RX resumes.
- Assert rst during a TX cycle → iocs=0 and databus Z immediately, fifo_count=0, overflow=0. After release, configuration sequence restarts.
